// File: rtl/risac_led_pkg.sv
// Shared constants for the risac LED/parallel-output peripheral: register
// addresses, per-bit mode encoding and the blink gating helper.
package risac_led_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_DIV      = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd3;
  localparam logic [2:0] ADDR_DUTY     = 3'd4;
  localparam logic [2:0] ADDR_PWM_MASK = 3'd5;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_BLINK  = 1'b1
  } led_mode_e;

  // A blinking bit follows the prescaler phase; a static bit passes through.
  function automatic logic blink_gate(input logic mode_bit, input logic phase);
    return (led_mode_e'(mode_bit) == MODE_BLINK) ? phase : 1'b1;
  endfunction

endpackage

// File: rtl/risac_led_prescaler.sv
// Reloadable down-counter producing a square-wave phase that toggles every
// DIV+1 cycles; a load strobe restarts the count without touching the phase.
module risac_led_prescaler #(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DIV_DEFAULT = 25000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_phase
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] ONE     = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_count;
  logic             r_phase;

  // Count down, reload from i_div on terminal count and flip the phase.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= DIV_RST;
      r_phase <= 1'b0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count == {DIV_W{1'b0}}) begin
      r_count <= i_div;
      r_phase <= ~r_phase;
    end else begin
      r_count <= r_count - ONE;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/risac_led_pio.sv
// Avalon-MM LED/parallel-output slave with per-bit static/blink and atomic toggle.
// Optional PWM dimming (DUTY/PWM_MASK) is enabled by defining RISAC_LED_PWM_EN.
module risac_led_pio
  import risac_led_pkg::*;
#(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DIV_DEFAULT = 25000000,
  parameter int unsigned PWM_W       = 8
) (
  input  logic             clock50,
  input  logic             reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  output logic [WIDTH-1:0] ledr
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mode;
  logic [DIV_W-1:0] r_div;
  logic [31:0]      r_readdata;
  logic [WIDTH-1:0] r_ledr;

  logic [WIDTH-1:0] w_wdata;
  logic             w_div_wr;
  logic             w_phase;
  logic [31:0]      w_rdata;
  logic [WIDTH-1:0] w_pwm_gate;
  logic [WIDTH-1:0] w_led_next;
  logic             w_unused;

  assign w_wdata  = avs_writedata[WIDTH-1:0];
  assign w_div_wr = avs_write && (avs_address == ADDR_DIV);
  assign w_unused = ^avs_writedata;

  // Base register file; reserved addresses and feature registers are ignored here.
  always_ff @(posedge clock50) begin
    if (!reset_n) begin
      r_data <= {WIDTH{1'b0}};
      r_mode <= {WIDTH{1'b0}};
      r_div  <= DIV_RST;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_DATA:   r_data <= w_wdata;
        ADDR_MODE:   r_mode <= w_wdata;
        ADDR_DIV:    r_div  <= avs_writedata[DIV_W-1:0];
        ADDR_TOGGLE: r_data <= r_data ^ w_wdata;
        default:     r_data <= r_data;
      endcase
    end
  end

  risac_led_prescaler #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_prescaler (
    .i_clk      (clock50),
    .i_rst_n    (reset_n),
    .i_div      (r_div),
    .i_load     (w_div_wr),
    .i_load_val (avs_writedata[DIV_W-1:0]),
    .o_phase    (w_phase)
  );

`ifdef RISAC_LED_PWM_EN
  localparam logic [PWM_W-1:0] PWM_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

  logic [PWM_W-1:0] r_duty;
  logic [WIDTH-1:0] r_pwm_mask;
  logic [PWM_W-1:0] r_pcnt;
  logic             w_pwm_on;

  // PWM configuration registers and the free-running PWM counter.
  always_ff @(posedge clock50) begin
    if (!reset_n) begin
      r_duty     <= {PWM_W{1'b0}};
      r_pwm_mask <= {WIDTH{1'b0}};
      r_pcnt     <= {PWM_W{1'b0}};
    end else begin
      r_pcnt <= r_pcnt + PWM_ONE;
      if (avs_write && (avs_address == ADDR_DUTY)) begin
        r_duty <= avs_writedata[PWM_W-1:0];
      end
      if (avs_write && (avs_address == ADDR_PWM_MASK)) begin
        r_pwm_mask <= w_wdata;
      end
    end
  end

  assign w_pwm_on   = (r_pcnt < r_duty);
  assign w_pwm_gate = ~r_pwm_mask | {WIDTH{w_pwm_on}};
`else
  logic [PWM_W-1:0] w_unused_pwm;

  assign w_unused_pwm = {PWM_W{1'b0}};
  assign w_pwm_gate   = {WIDTH{1'b1}};
`endif

  // Read mux: zero-extended view of the registers as they stand before this edge.
  always_comb begin
    w_rdata = 32'd0;
    case (avs_address)
      ADDR_DATA:     w_rdata[WIDTH-1:0] = r_data;
      ADDR_MODE:     w_rdata[WIDTH-1:0] = r_mode;
      ADDR_DIV:      w_rdata[DIV_W-1:0] = r_div;
`ifdef RISAC_LED_PWM_EN
      ADDR_DUTY:     w_rdata[PWM_W-1:0] = r_duty;
      ADDR_PWM_MASK: w_rdata[WIDTH-1:0] = r_pwm_mask;
`endif
      default:       w_rdata = 32'd0;
    endcase
  end

  // Per-bit output composition: data, blink gating and PWM gating.
  always_comb begin
    w_led_next = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_led_next[i] = r_data[i] & blink_gate(r_mode[i], w_phase) & w_pwm_gate[i];
    end
  end

  // Registered outputs; readdata holds between reads.
  always_ff @(posedge clock50) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
      r_ledr     <= {WIDTH{1'b0}};
    end else begin
      r_ledr <= w_led_next;
      if (avs_read) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign avs_readdata = r_readdata;
  assign ledr         = r_ledr;

endmodule

// File: tb/tb_risac_led_pio.sv
// Scoreboard bench for risac_led_pio; expectations follow RISAC_LED_PWM_EN.
module tb_risac_led_pio;

  logic        clock50;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [9:0]  ledr;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q[$];
  string       rd_nq[$];
  logic [31:0] ck_q[$];
  int          ck_kq[$];
  string       ck_nq[$];
  bit          rd_valid = 1'b0;
  bit          ck_stb   = 1'b0;
  bit          done     = 1'b0;
  bit          done_seen = 1'b0;
  int          pwm_hits = 0;

  risac_led_pio dut (
    .clock50       (clock50),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .ledr          (ledr)
  );

  initial clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  // readdata is valid the cycle after a read strobe
  always @(posedge clock50) rd_valid <= avs_read;

  always @(negedge clock50) begin
    logic [31:0] e;
    logic [31:0] act;
    string n;
    int k;
    if (rd_valid) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected readdata=%h with no expected entry", avs_readdata);
      end else begin
        e = rd_q.pop_front();
        n = rd_nq.pop_front();
        if (avs_readdata !== e) begin
          errors++;
          $display("FAIL %s readdata=%h expected=%h", n, avs_readdata, e);
        end
      end
    end
    if (ck_stb) begin
      checks++;
      if (ck_q.size() == 0) begin
        errors++;
        $display("FAIL ck_unexpected check strobe with no expected entry");
      end else begin
        e = ck_q.pop_front();
        k = ck_kq.pop_front();
        n = ck_nq.pop_front();
        case (k)
          0:       act = {22'd0, ledr};
          1:       act = avs_readdata;
          default: act = 32'(pwm_hits);
        endcase
        if (act !== e) begin
          errors++;
          $display("FAIL %s got=%h expected=%h", n, act, e);
        end
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      checks++;
      if (rd_q.size() != 0 || ck_q.size() != 0) begin
        errors++;
        $display("FAIL drain pending rd=%0d ck=%0d expected 0", rd_q.size(), ck_q.size());
      end
    end
  end

  task automatic cyc();
    @(posedge clock50);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    avs_address = a; avs_read = 1'b1;
    rd_q.push_back(e); rd_nq.push_back(n);
    cyc();
    avs_read = 1'b0;
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
    avs_address = a; avs_writedata = d; avs_write = 1'b1; avs_read = 1'b1;
    rd_q.push_back(e); rd_nq.push_back(n);
    cyc();
    avs_write = 1'b0; avs_read = 1'b0;
  endtask

  // kind 0: ledr, 1: readdata, 2: pwm window count
  task automatic chk(input int k, input logic [31:0] e, input string n);
    ck_q.push_back(e); ck_kq.push_back(k); ck_nq.push_back(n);
    ck_stb = 1'b1;
    cyc();
    ck_stb = 1'b0;
  endtask

  task automatic pwm_window(input int e, input string n);
    pwm_hits = 0;
    for (int i = 0; i < 256; i++) begin
      pwm_hits += int'(ledr[0]);
      cyc();
    end
    chk(2, 32'(e), n);
  endtask

  initial begin
    reset_n = 1'b0; avs_address = 3'd0; avs_write = 1'b1;
    avs_writedata = 32'h0000_03FF; avs_read = 1'b0;
    cyc();
    chk(0, 32'h0, "rst_ledr");
    chk(1, 32'h0, "rst_rdata");
    reset_n = 1'b1; avs_write = 1'b0;
    rd(3'd2, 32'd25000000, "rst_div");
    rd(3'd0, 32'h0, "rst_data");

    wr(3'd0, 32'h0000_02A5);
    chk(0, 32'h0, "wr_lat1");
    chk(0, 32'h2A5, "wr_lat2");
    rd(3'd0, 32'h0000_02A5, "rd_data");

    wr(3'd3, 32'h0000_03FF);
    rd(3'd3, 32'h0, "rd_toggle");
    chk(0, 32'h15A, "toggle_led");
    rd(3'd0, 32'h15A, "toggle_data");

    wr(3'd0, 32'hFFFF_F001);
    rd(3'd0, 32'h001, "upper_ignored");
    rw(3'd0, 32'h002, 32'h001, "rw_old");
    rd(3'd0, 32'h002, "rw_new");
    wr(3'd6, 32'h123);
    rd(3'd6, 32'h0, "rsvd6");
    rd(3'd7, 32'h0, "rsvd7");

    wr(3'd0, 32'h3FF);
    wr(3'd1, 32'h001);
    rd(3'd1, 32'h001, "rd_mode");
    wr(3'd2, 32'd3);
    for (int j = 0; j <= 16; j++) begin
      chk(0, ((j >= 5 && j <= 8) || j >= 13) ? 32'h3FF : 32'h3FE, $sformatf("blink%0d", j));
    end
    wr(3'd2, 32'd9);
    chk(0, 32'h3FE, "div9_a");
    chk(0, 32'h3FE, "div9_b");
    wr(3'd2, 32'd1);
    chk(0, 32'h3FE, "div1_0");
    chk(0, 32'h3FE, "div1_1");
    chk(0, 32'h3FE, "div1_2");
    chk(0, 32'h3FF, "div1_3");
    chk(0, 32'h3FF, "div1_4");
    chk(0, 32'h3FE, "div1_5");

    reset_n = 1'b0; avs_address = 3'd0; avs_writedata = 32'h155; avs_write = 1'b1;
    cyc();
    reset_n = 1'b1; avs_write = 1'b0;
    chk(0, 32'h0, "mid_rst_ledr");
    chk(1, 32'h0, "mid_rst_rdata");
    rd(3'd1, 32'h0, "mid_rst_mode");
    rd(3'd2, 32'd25000000, "mid_rst_div");

    wr(3'd0, 32'h001);
    wr(3'd5, 32'h001);
    wr(3'd4, 32'd64);
    cyc();
`ifdef RISAC_LED_PWM_EN
    pwm_window(64, "pwm64");
    rd(3'd4, 32'd64, "rd_duty");
    rd(3'd5, 32'h001, "rd_mask");
    wr(3'd4, 32'd0);
    cyc();
    pwm_window(0, "pwm0");
`else
    pwm_window(256, "pwm64_off");
    rd(3'd4, 32'h0, "rd_duty");
    rd(3'd5, 32'h0, "rd_mask");
    wr(3'd4, 32'd0);
    cyc();
    pwm_window(256, "pwm0_off");
`endif

    done = 1'b1;
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
